// File: rtl/jtdd_video_pkg.sv
`default_nettype none
// ============================================================================
// Module   : jtdd_video_pkg
// Brief    : Shared types for the Double Dragon video path: graphics ROM
//            client ids, arbiter FSM states and the round-robin pick helper.
// Revision : 1.0 - initial release
// ============================================================================
package jtdd_video_pkg;

  // Graphics ROM clients sharing the single SDRAM slot
  typedef enum logic [1:0] {
    CL_CHAR = 2'd0,
    CL_SCR  = 2'd1,
    CL_OBJ  = 2'd2
  } client_e;

  // Arbiter FSM states
  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_ACK  = 2'd1,
    ST_WAIT_DATA = 2'd2
  } state_e;

  // Widest client word address (object ROM)
  localparam int GADDR_W = 19;

  // Round-robin pick over char -> scr -> obj, starting after the last grant.
  // miss[0]=char, miss[1]=scr, miss[2]=obj. Only meaningful when |miss.
  function automatic client_e rr_pick(input logic [2:0] miss, input client_e last);
    client_e pick;
    pick = CL_CHAR;
    case (last)
      CL_CHAR: begin
        if (miss[1])      pick = CL_SCR;
        else if (miss[2]) pick = CL_OBJ;
        else              pick = CL_CHAR;
      end
      CL_SCR: begin
        if (miss[2])      pick = CL_OBJ;
        else if (miss[0]) pick = CL_CHAR;
        else              pick = CL_SCR;
      end
      default: begin
        if (miss[0])      pick = CL_CHAR;
        else if (miss[1]) pick = CL_SCR;
        else              pick = CL_OBJ;
      end
    endcase
    return pick;
  endfunction

endpackage
`default_nettype wire

// File: rtl/jtdd_gfx_cache.sv
`default_nettype none
// ============================================================================
// Module   : jtdd_gfx_cache
// Brief    : One-entry graphics ROM cache for a single client. Holds tag,
//            data and valid bit, flags a miss, and registers ok/data.
// Revision : 1.0 - initial release
// ============================================================================
module jtdd_gfx_cache #(
  parameter int AW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cs_i,
  input  logic [AW-1:0] addr_i,
  input  logic          wr_i,
  input  logic [AW-1:0] wr_addr_i,
  input  logic [15:0]   wr_data_i,
  output logic          hit_o,
  output logic          miss_o,
  output logic          ok_o,
  output logic [15:0]   data_o
);

  logic          valid_q;
  logic [AW-1:0] tag_q;
  logic [15:0]   cdata_q;
  logic          ok_q;
  logic [15:0]   dout_q;
  logic          hit;

  // A client that is not selecting never counts as a miss
  assign hit    = cs_i & valid_q & (tag_q == addr_i);
  assign hit_o  = hit;
  assign miss_o = cs_i & ~hit;
  assign ok_o   = ok_q;
  assign data_o = dout_q;

  // Fill the entry on a returned burst; publish ok/data one cycle after a hit
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      tag_q   <= '0;
      cdata_q <= '0;
      ok_q    <= 1'b0;
      dout_q  <= '0;
    end else begin
      if (wr_i) begin
        valid_q <= 1'b1;
        tag_q   <= wr_addr_i;
        cdata_q <= wr_data_i;
      end
      ok_q <= hit;
      if (hit) dout_q <= cdata_q;
    end
  end

endmodule
`default_nettype wire

// File: rtl/jtdd_gfx_arb.sv
`default_nettype none
// ============================================================================
// Module   : jtdd_gfx_arb
// Brief    : Graphics ROM arbiter. Char, scroll and object engines share one
//            SDRAM read slot through per-client one-entry caches; misses are
//            granted round-robin with a single outstanding burst.
// Revision : 1.0 - initial release
// ============================================================================
module jtdd_gfx_arb
  import jtdd_video_pkg::*;
#(
  parameter logic [21:0] CHAR_OFFSET = 22'h00000,
  parameter logic [21:0] SCR_OFFSET  = 22'h08000,
  parameter logic [21:0] OBJ_OFFSET  = 22'h18000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        char_cs,
  input  logic [15:0] char_addr,
  output logic [7:0]  char_data,
  output logic        char_ok,
  input  logic        scr_cs,
  input  logic [16:0] scr_addr,
  output logic [15:0] scr_data,
  output logic        scr_ok,
  input  logic        obj_cs,
  input  logic [18:0] obj_addr,
  output logic [15:0] obj_data,
  output logic        obj_ok,
  output logic        sdram_req,
  output logic [21:0] sdram_addr,
  input  logic        sdram_ack,
  input  logic        sdram_rdy,
  input  logic [15:0] sdram_din
);

  state_e              state_q;
  client_e             gid_q;
  client_e             last_q;
  logic [GADDR_W-1:0]  gaddr_q;
  logic                req_q;
  logic [21:0]         addr_q;
  logic                csel_q;

  logic [2:0]          miss;
  logic                char_hit, scr_hit, obj_hit;
  logic [15:0]         char_word;
  client_e             pick_d;
  logic [GADDR_W-1:0]  pick_addr_d;
  logic [21:0]         pick_sdram_d;
  logic                wr_fire;

  // Data lands either in WAIT_DATA or together with the ack in WAIT_ACK
  assign wr_fire = ((state_q == ST_WAIT_ACK) & sdram_ack & sdram_rdy) |
                   ((state_q == ST_WAIT_DATA) & sdram_rdy);

  jtdd_gfx_cache #(.AW(15)) u_char (
    .clk       (clk),
    .rst       (rst),
    .cs_i      (char_cs),
    .addr_i    (char_addr[15:1]),
    .wr_i      (wr_fire & (gid_q == CL_CHAR)),
    .wr_addr_i (gaddr_q[14:0]),
    .wr_data_i (sdram_din),
    .hit_o     (char_hit),
    .miss_o    (miss[0]),
    .ok_o      (char_ok),
    .data_o    (char_word)
  );

  jtdd_gfx_cache #(.AW(17)) u_scr (
    .clk       (clk),
    .rst       (rst),
    .cs_i      (scr_cs),
    .addr_i    (scr_addr),
    .wr_i      (wr_fire & (gid_q == CL_SCR)),
    .wr_addr_i (gaddr_q[16:0]),
    .wr_data_i (sdram_din),
    .hit_o     (scr_hit),
    .miss_o    (miss[1]),
    .ok_o      (scr_ok),
    .data_o    (scr_data)
  );

  jtdd_gfx_cache #(.AW(19)) u_obj (
    .clk       (clk),
    .rst       (rst),
    .cs_i      (obj_cs),
    .addr_i    (obj_addr),
    .wr_i      (wr_fire & (gid_q == CL_OBJ)),
    .wr_addr_i (gaddr_q),
    .wr_data_i (sdram_din),
    .hit_o     (obj_hit),
    .miss_o    (miss[2]),
    .ok_o      (obj_ok),
    .data_o    (obj_data)
  );

  // Byte lane follows the char address that produced the registered word
  always_ff @(posedge clk) begin
    if (rst) csel_q <= 1'b0;
    else if (char_hit) csel_q <= char_addr[0];
  end

  assign char_data = csel_q ? char_word[15:8] : char_word[7:0];

  // Round-robin winner and its word/SDRAM address; the offset sum wraps at 22 bits
  always_comb begin
    pick_d       = rr_pick(miss, last_q);
    pick_addr_d  = '0;
    pick_sdram_d = '0;
    case (pick_d)
      CL_CHAR: begin
        pick_addr_d  = {4'b0, char_addr[15:1]};
        pick_sdram_d = CHAR_OFFSET + {7'b0, char_addr[15:1]};
      end
      CL_SCR: begin
        pick_addr_d  = {2'b0, scr_addr};
        pick_sdram_d = SCR_OFFSET + {5'b0, scr_addr};
      end
      default: begin
        pick_addr_d  = obj_addr;
        pick_sdram_d = OBJ_OFFSET + {3'b0, obj_addr};
      end
    endcase
  end

  // Arbiter FSM: one burst at a time, registered request and address
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      gid_q   <= CL_CHAR;
      last_q  <= CL_OBJ;
      gaddr_q <= '0;
      req_q   <= 1'b0;
      addr_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (|miss) begin
            gid_q   <= pick_d;
            gaddr_q <= pick_addr_d;
            req_q   <= 1'b1;
            addr_q  <= pick_sdram_d;
            state_q <= ST_WAIT_ACK;
          end
        end
        ST_WAIT_ACK: begin
          if (sdram_ack) begin
            req_q <= 1'b0;
            if (sdram_rdy) begin
              last_q  <= gid_q;
              state_q <= ST_IDLE;
            end else begin
              state_q <= ST_WAIT_DATA;
            end
          end
        end
        ST_WAIT_DATA: begin
          if (sdram_rdy) begin
            last_q  <= gid_q;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign sdram_req  = req_q;
  assign sdram_addr = addr_q;

endmodule
`default_nettype wire

// File: tb/tb_jtdd_gfx_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_jtdd_gfx_arb
// Brief    : Scoreboard bench for the graphics ROM arbiter. Stimulus pushes
//            expected SDRAM addresses and client data; a monitor pops and
//            compares on each request rise and each ok rise.
// Revision : 1.0 - initial release
// ============================================================================
module tb_jtdd_gfx_arb;

  localparam logic [21:0] CHAR_OFF = 22'h00000;
  localparam logic [21:0] SCR_OFF  = 22'h08000;
  localparam logic [21:0] OBJ_OFF  = 22'h3FFFFF;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        char_cs = 1'b0;
  logic [15:0] char_addr = '0;
  logic [7:0]  char_data;
  logic        char_ok;
  logic        scr_cs = 1'b0;
  logic [16:0] scr_addr = '0;
  logic [15:0] scr_data;
  logic        scr_ok;
  logic        obj_cs = 1'b0;
  logic [18:0] obj_addr = '0;
  logic [15:0] obj_data;
  logic        obj_ok;
  logic        sdram_req;
  logic [21:0] sdram_addr;
  logic        sdram_ack = 1'b0;
  logic        sdram_rdy = 1'b0;
  logic [15:0] sdram_din = '0;

  always #5 clk = ~clk;

  jtdd_gfx_arb #(
    .CHAR_OFFSET (CHAR_OFF),
    .SCR_OFFSET  (SCR_OFF),
    .OBJ_OFFSET  (OBJ_OFF)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .char_cs    (char_cs),
    .char_addr  (char_addr),
    .char_data  (char_data),
    .char_ok    (char_ok),
    .scr_cs     (scr_cs),
    .scr_addr   (scr_addr),
    .scr_data   (scr_data),
    .scr_ok     (scr_ok),
    .obj_cs     (obj_cs),
    .obj_addr   (obj_addr),
    .obj_data   (obj_data),
    .obj_ok     (obj_ok),
    .sdram_req  (sdram_req),
    .sdram_addr (sdram_addr),
    .sdram_ack  (sdram_ack),
    .sdram_rdy  (sdram_rdy),
    .sdram_din  (sdram_din)
  );

  int tests = 0;
  int fails = 0;

  logic [21:0] q_req[$];
  logic [15:0] q_char[$];
  logic [15:0] q_scr[$];
  logic [15:0] q_obj[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic        prev_req = 1'b0;
  logic [21:0] prev_addr = '0;
  logic        pending = 1'b0;
  logic        acked = 1'b0;
  logic        prev_cok = 1'b0, prev_sok = 1'b0, prev_ook = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      pending = 1'b0;
      acked   = 1'b0;
    end else begin
      if (sdram_req && !prev_req) begin
        check("req_overlap", {31'b0, pending}, 32'd0);
        if (q_req.size() == 0) begin
          tests++; fails++;
          $display("FAIL req_addr: unexpected request at %0h, none expected", sdram_addr);
        end else begin
          check("req_addr", {10'b0, sdram_addr}, {10'b0, q_req.pop_front()});
        end
        pending = 1'b1;
        acked   = 1'b0;
      end
      if (sdram_req && prev_req && (sdram_addr != prev_addr))
        check("req_addr_stable", {10'b0, sdram_addr}, {10'b0, prev_addr});
      if (pending && sdram_ack) acked = 1'b1;
      if (pending && acked && sdram_rdy) pending = 1'b0;
    end

    if (char_ok && !prev_cok) begin
      if (q_char.size() == 0) begin
        tests++; fails++;
        $display("FAIL char_ok: unexpected rise with data %0h, none expected", char_data);
      end else check("char_data", {24'b0, char_data}, {16'b0, q_char.pop_front()});
    end
    if (scr_ok && !prev_sok) begin
      if (q_scr.size() == 0) begin
        tests++; fails++;
        $display("FAIL scr_ok: unexpected rise with data %0h, none expected", scr_data);
      end else check("scr_data", {16'b0, scr_data}, {16'b0, q_scr.pop_front()});
    end
    if (obj_ok && !prev_ook) begin
      if (q_obj.size() == 0) begin
        tests++; fails++;
        $display("FAIL obj_ok: unexpected rise with data %0h, none expected", obj_data);
      end else check("obj_data", {16'b0, obj_data}, {16'b0, q_obj.pop_front()});
    end

    prev_req  = sdram_req;
    prev_addr = sdram_addr;
    prev_cok  = char_ok;
    prev_sok  = scr_ok;
    prev_ook  = obj_ok;
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req(input string nm);
    int n;
    n = 0;
    while (sdram_req !== 1'b1 && n < 64) begin
      tick();
      n++;
    end
    check(nm, {31'b0, sdram_req}, 32'd1);
  endtask

  task automatic serve(input logic [15:0] d, input int gap);
    sdram_ack = 1'b1;
    tick();
    sdram_ack = 1'b0;
    repeat (gap) tick();
    sdram_rdy = 1'b1;
    sdram_din = d;
    tick();
    sdram_rdy = 1'b0;
    sdram_din = '0;
  endtask

  task automatic do_reset();
    char_cs = 1'b0; scr_cs = 1'b0; obj_cs = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // ---------------- directed vectors ----------------
  initial begin
    // Reset state
    tick();
    tick();
    check("rst_req", {31'b0, sdram_req}, 32'd0);
    check("rst_addr", {10'b0, sdram_addr}, 32'd0);
    check("rst_oks", {29'b0, char_ok, scr_ok, obj_ok}, 32'd0);
    check("rst_char_data", {24'b0, char_data}, 32'd0);
    check("rst_scr_data", {16'b0, scr_data}, 32'd0);
    check("rst_obj_data", {16'b0, obj_data}, 32'd0);
    rst = 1'b0;
    tick();

    // Single char miss, odd byte, then even-byte hit on the same word
    q_req.push_back(22'h000009);
    q_char.push_back(16'h00A5);
    char_cs = 1'b1; char_addr = 16'h0013;
    wait_req("t1_req");
    serve(16'hA55A, 2);
    tick();
    check("t1_ok", {31'b0, char_ok}, 32'd1);
    check("t1_data_hi", {24'b0, char_data}, 32'hA5);
    char_addr = 16'h0012;
    tick();
    check("t1_data_lo", {24'b0, char_data}, 32'h5A);
    check("t1_ok_hold", {31'b0, char_ok}, 32'd1);
    repeat (4) tick();
    check("t1_no_req", {31'b0, sdram_req}, 32'd0);

    // Three simultaneous misses, two rounds of round-robin
    do_reset();
    q_req.push_back(22'h000100); q_req.push_back(22'h008010); q_req.push_back(22'h00001F);
    q_char.push_back(16'h0011); q_scr.push_back(16'h2222); q_obj.push_back(16'h3333);
    char_cs = 1'b1; char_addr = 16'h0200;
    scr_cs  = 1'b1; scr_addr  = 17'h00010;
    obj_cs  = 1'b1; obj_addr  = 19'h00020;
    wait_req("t2_req0"); serve(16'h1111, 1);
    wait_req("t2_req1"); serve(16'h2222, 1);
    wait_req("t2_req2"); serve(16'h3333, 1);
    repeat (3) tick();
    q_req.push_back(22'h000200); q_req.push_back(22'h008011); q_req.push_back(22'h000020);
    q_char.push_back(16'h0044); q_scr.push_back(16'h6677); q_obj.push_back(16'h8899);
    char_addr = 16'h0401; scr_addr = 17'h00011; obj_addr = 19'h00021;
    wait_req("t2_req3"); serve(16'h4455, 0);
    wait_req("t2_req4"); serve(16'h6677, 0);
    wait_req("t2_req5"); serve(16'h8899, 0);
    repeat (3) tick();
    check("t2_all_ok", {29'b0, char_ok, scr_ok, obj_ok}, 32'd7);

    // Object address changes while its fetch is in flight
    do_reset();
    q_req.push_back(22'h0000FF);
    obj_cs = 1'b1; obj_addr = 19'h00100;
    wait_req("t3_req0");
    sdram_ack = 1'b1;
    tick();
    sdram_ack = 1'b0;
    tick();
    q_req.push_back(22'h000100);
    obj_addr = 19'h00101;
    tick();
    sdram_rdy = 1'b1; sdram_din = 16'hDEAD;
    tick();
    sdram_rdy = 1'b0; sdram_din = '0;
    tick();
    check("t3_ok_low", {31'b0, obj_ok}, 32'd0);
    wait_req("t3_req1");
    q_obj.push_back(16'hBEEF);
    serve(16'hBEEF, 1);
    tick();
    check("t3_ok_after", {31'b0, obj_ok}, 32'd1);

    // Same-cycle ack and rdy in WAIT_ACK
    do_reset();
    q_req.push_back(22'h000003); q_req.push_back(22'h008005);
    q_char.push_back(16'h00FE); q_scr.push_back(16'h1234);
    char_cs = 1'b1; char_addr = 16'h0006;
    scr_cs  = 1'b1; scr_addr  = 17'h00005;
    wait_req("t4_req0");
    sdram_ack = 1'b1; sdram_rdy = 1'b1; sdram_din = 16'hCAFE;
    tick();
    sdram_ack = 1'b0; sdram_rdy = 1'b0; sdram_din = '0;
    check("t4_idle_gap", {31'b0, sdram_req}, 32'd0);
    tick();
    check("t4_next_req", {31'b0, sdram_req}, 32'd1);
    check("t4_next_addr", {10'b0, sdram_addr}, 32'h008005);
    serve(16'h1234, 0);
    repeat (2) tick();

    // Reset while waiting for data
    do_reset();
    q_req.push_back(22'h000008);
    q_char.push_back(16'h00AA);
    char_cs = 1'b1; char_addr = 16'h0010;
    wait_req("t5_req0");
    serve(16'h11AA, 0);
    tick();
    check("t5_ok_pre", {31'b0, char_ok}, 32'd1);
    q_req.push_back(22'h008002);
    scr_cs = 1'b1; scr_addr = 17'h00002;
    wait_req("t5_req1");
    sdram_ack = 1'b1;
    tick();
    sdram_ack = 1'b0;
    rst = 1'b1; char_cs = 1'b0; scr_cs = 1'b0;
    tick();
    check("t5_rst_oks", {29'b0, char_ok, scr_ok, obj_ok}, 32'd0);
    check("t5_rst_req", {31'b0, sdram_req}, 32'd0);
    rst = 1'b0;
    tick();
    sdram_rdy = 1'b1; sdram_din = 16'h5555;
    tick();
    sdram_rdy = 1'b0; sdram_din = '0;
    repeat (2) tick();
    check("t5_late_rdy_req", {31'b0, sdram_req}, 32'd0);
    check("t5_late_rdy_ok", {29'b0, char_ok, scr_ok, obj_ok}, 32'd0);
    q_req.push_back(22'h000008);
    char_cs = 1'b1; char_addr = 16'h0010;
    wait_req("t5_remiss");
    q_char.push_back(16'h00BB);
    serve(16'h22BB, 0);
    repeat (2) tick();

    // Offset wrap
    do_reset();
    q_req.push_back(22'h000000);
    q_obj.push_back(16'h7E7E);
    obj_cs = 1'b1; obj_addr = 19'h00001;
    wait_req("t6_req");
    serve(16'h7E7E, 1);
    repeat (5) tick();

    check("q_req_empty", q_req.size(), 32'd0);
    check("q_char_empty", q_char.size(), 32'd0);
    check("q_scr_empty", q_scr.size(), 32'd0);
    check("q_obj_empty", q_obj.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/jtdd_gfx_arb.md
# jtdd_gfx_arb

Graphics ROM arbiter for the Double Dragon video path. It lets the char, scroll and object tile engines share one SDRAM read slot. Each engine keeps its usual address/ok handshake, backed by a one-entry cache per client. The arbiter issues at most one outstanding SDRAM burst at a time and grants clients round-robin. It sits between the video block's ROM ports and the SDRAM controller's single graphics slot.

## Interface
Parameters:
- CHAR_OFFSET, 22'h00000: word base of the char ROM in the graphics region.
- SCR_OFFSET, 22'h08000: word base of the scroll ROM.
- OBJ_OFFSET, 22'h18000: word base of the object ROM.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high (one clock; sync active-high reset is fixed)
- char_cs  in  1  char request active
- char_addr  in  16  char byte address
- char_data  out  8  char byte
- char_ok  out  1  char_data valid for current char_addr
- scr_cs / scr_addr  in  1 / 17  scroll request; word address
- scr_data / scr_ok  out  16 / 1  scroll word and valid
- obj_cs / obj_addr  in  1 / 19  object request; word address
- obj_data / obj_ok  out  16 / 1  object word and valid
- sdram_req  out  1  read request to SDRAM slot
- sdram_addr  out  22  word address
- sdram_ack  in  1  one-cycle pulse: request accepted
- sdram_rdy  in  1  one-cycle pulse: sdram_din valid
- sdram_din  in  16  read data

## Operation
- Each client has a cache entry: valid bit, tag (word address), 16-bit data. Char tag is char_addr[15:1]. char_data is din[7:0] when char_addr[0]=0, otherwise din[15:8].
- hit = cs & valid & (tag == current word address). miss = cs & !hit. A client with cs=0 is never a miss.
- sdram_addr = OFFSET + zero-extended word address. The sum is 22-bit and wraps modulo 2^22.
- FSM states: IDLE, WAIT_ACK, WAIT_DATA.
  - IDLE: if any miss, choose the winner round-robin. Order is char → scr → obj, starting after the last granted client. After reset the last granted client is obj, so char ranks first. Latch the winner id and its word address (gaddr), drive sdram_req=1 with that address, go to WAIT_ACK.
  - WAIT_ACK: hold sdram_req and sdram_addr stable. When sdram_ack=1, drop sdram_req and go to WAIT_DATA.
  - WAIT_DATA: when sdram_rdy=1, write tag=gaddr, data=sdram_din and valid=1 to the winner's entry. Update last-granted and go to IDLE.
- If the client address changes while its fetch is in flight, the returned data is still cached under gaddr. The next hit compare fails and a new miss is raised. Nothing is discarded silently and no stale ok is produced.
- sdram_ack and sdram_rdy in the same cycle while in WAIT_ACK: treat it as ack then data. The cache is written and the FSM goes to IDLE.
- sdram_rdy outside WAIT_DATA is ignored.
- Reset: state to IDLE, all valid bits to 0, last-granted to obj. Outputs reset to sdram_req=0, sdram_addr=0, all ok=0, all data=0. A reset during WAIT_ACK or WAIT_DATA abandons the fetch.

## Timing
- ok and data are registered. X_ok=1 in the cycle after a hit is seen, and stays 1 while the hit holds. ok drops the cycle after addr changes to a non-matching value or cs falls.
- Miss latency with an idle FSM, ack in cycle n+k and rdy in cycle n+k+m:
  - miss seen at edge n;
  - sdram_req high from n+1;
  - cache written at the rdy edge;
  - ok=1 one cycle later.
- Minimum turnaround from rdy to the next sdram_req: 1 cycle (IDLE decision cycle).
- Only one SDRAM request is outstanding. Other misses wait in IDLE order and their ok stays 0.

## Structure
- Client ids (CHAR=0, SCR=1, OBJ=2) and FSM state encoding go in a shared jtdd_video package.
- One sub-module, jtdd_gfx_cache, instantiated three times. It holds the tag, data and valid bit, does the hit compare, and registers ok/data. It is parameterised by address width.
- The round-robin pick and the FSM stay in the top.

## Test plan
- Single char miss: char_cs=1, char_addr=16'h0013. Expect sdram_req with sdram_addr=22'h000009. Give ack, then rdy with din=16'hA55A. Expect char_ok=1 and char_data=8'hA5 one cycle after rdy. Then addr 16'h0012 hits with data 8'h5A and no new request.
- Three simultaneous misses: grant order is char, scr, obj. Then rerequest all three with new addresses; the order continues char, scr, obj per the round-robin pointer. No sdram_req overlaps another.
- Address change mid-fetch: obj_addr 0x100 is granted, obj_addr switches to 0x101 before rdy. Expect obj_ok to stay 0, then a new request at OBJ_OFFSET+0x101, and obj_ok=1 only after that data returns.
- Same-cycle ack+rdy in WAIT_ACK: expect the cache to be written, the FSM back in IDLE, and the next pending miss requested the following cycle.
- Reset asserted in WAIT_DATA: expect all ok=0, sdram_req=0 next cycle, a late rdy ignored, and the previously valid hit address missing again after reset.
- Offset wrap: OBJ_OFFSET=22'h3FFFFF, obj_addr=1 → sdram_addr=22'h000000.
